pc_gen_way0: RTL
================

// Module: pc_gen_way0
// PURPOSE
//   Program-counter generator directly upstream of the way-0 instruction fetch unit.
//   - Produces the fetch address and fetch-request valid that drive the fetch unit's instAddr_i/valid_i.
//   - Caps outstanding fetches.
//   - On a redirect (jump), drains in-flight fetches with a kill flag, then restarts at the jump target.
// PARAMETERS
//   RESET_PC         32'h8000_0000  first fetch address after reset (before way offset)
//   WAY_OFFSET       32'h0          byte offset of this way within an 8-byte fetch pair (way0=0, way1=4)
//   PC_STEP          32'h8          address increment per issued fetch (two ways x 4 bytes)
//   MAX_OUTSTANDING  2              max issued-but-unconsumed fetches, >=1
// PORTS
//   clk           in   1   clock, all state on rising edge
//   reset         in   1   asynchronous, active-high reset
//   stall_i       in   1   back-end stall; suppresses new issue only
//   jump_flag_i   in   1   redirect request, single-cycle pulse
//   jump_addr_i   in   32  redirect target
//   fetch_ack_i   in   1   fetch unit consumed one fetch (its ready_o)
//   valid_o       out  1   fetch request this cycle (to fetch unit valid_i)
//   inst_addr_o   out  32  fetch address (to fetch unit instAddr_i)
//   kill_o        out  1   returning fetch data is stale; downstream discards it
//   outstanding_o out  CW  in-flight fetch count, CW=$clog2(MAX_OUTSTANDING+1)
// BEHAVIOUR
//   Registers: pc (32b), cnt (CW b), state {BOOT, RUN, DRAIN}.
//   Reset (async, immediate):
//     pc=RESET_PC|WAY_OFFSET, cnt=0, state=BOOT
//     Outputs during reset: valid_o=0, kill_o=0, outstanding_o=0, inst_addr_o=RESET_PC|WAY_OFFSET.
//   inst_addr_o=pc and outstanding_o=cnt, both straight from registers.
//   issue = (state==RUN) & (cnt<MAX_OUTSTANDING) & ~stall_i & ~jump_flag_i.
//   valid_o = issue, combinational; no backpressure, the request is taken the same cycle.
//   retire = fetch_ack_i & (cnt!=0); an ack with cnt==0 is ignored.
//   cnt_next = cnt + issue - retire. Simultaneous issue+retire leaves cnt unchanged. cnt never exceeds MAX.
//   pc update:
//     issue -> pc+PC_STEP, mod 2^32 (0xFFFF_FFF8+8 wraps to 0x0)
//     jump  -> {jump_addr_i[31:3],3'b000}|WAY_OFFSET
//     Jump has priority over issue (issue is forced 0 that cycle).
//   FSM:
//     BOOT : one idle cycle after reset release -> RUN. A jump in BOOT still loads pc.
//     RUN  : jump_flag_i & (cnt_next!=0) -> DRAIN
//            jump_flag_i & (cnt_next==0) -> stay RUN; first fetch of the target issues next cycle.
//     DRAIN: kill_o=1, issue=0. retire decrements cnt.
//            Leave for RUN when cnt_next==0. A further jump in DRAIN reloads pc and stays in DRAIN.
//   kill_o = (state==DRAIN), combinational from state.
//     The fetch unit qualifies data with kill_o.
//     An ack arriving in the same cycle as the jump belongs to pre-jump data and is not killed.
//   stall_i in DRAIN has no effect on the drain. stall_i never blocks retire.
//   Latency: jump pulse cycle N, cnt_next==0 -> valid_o=1 with target address in cycle N+1.
//   Reset asserted mid-DRAIN/RUN aborts everything: in-flight count discarded, BOOT re-entered.
// TESTING
//   1. Reset release, fetch_ack_i tied to issue one cycle later:
//      valid_o=0 in BOOT; addresses 0x8000_0000, 0x8000_0008, 0x8000_0010 on consecutive cycles.
//   2. fetch_ack_i held 0:
//      exactly 2 issues (0x8000_0000, 0x8000_0008), then valid_o=0 with outstanding_o=2.
//      One ack -> one more issue at 0x8000_0010.
//   3. cnt=2, jump to 0x8000_1234:
//      kill_o=1 with no issue until 2 acks.
//      Next cycle valid_o=1, inst_addr_o=0x8000_1230; way1 build (WAY_OFFSET=4) gives 0x8000_1234.
//   4. Jump to 0x100 during DRAIN, then jump to 0x200 before the drain completes:
//      restart address is 0x200; no valid_o while kill_o=1.
//   5. pc=0xFFFF_FFF8, issue -> pc wraps to 0x0.
//      Issue and ack in the same cycle at cnt=1 -> cnt stays 1.
//      Ack with cnt=0 -> cnt stays 0.
//   6. Assert reset mid-DRAIN with cnt=1:
//      all outputs go to reset values immediately; after release, one BOOT cycle, then fetch at RESET_PC.

Source files
------------

// File: rtl/pc_gen_way0_if.sv
// Fetch-request interface between the PC generator and the way-0 fetch unit.
//   stall_i       back-end stall (suppresses new issue)
//   jump_flag_i   redirect pulse
//   jump_addr_i   redirect target
//   fetch_ack_i   fetch unit consumed one fetch
//   valid_o       fetch request this cycle
//   inst_addr_o   fetch address
//   kill_o        returning fetch data is stale
//   outstanding_o in-flight fetch count
interface pc_gen_way0_if #(
   parameter int unsigned CW = 2
);
   logic          stall_i;
   logic          jump_flag_i;
   logic [31:0]   jump_addr_i;
   logic          fetch_ack_i;
   logic          valid_o;
   logic [31:0]   inst_addr_o;
   logic          kill_o;
   logic [CW-1:0] outstanding_o;

   // PC generator side
   modport master (
      input  stall_i, jump_flag_i, jump_addr_i, fetch_ack_i,
      output valid_o, inst_addr_o, kill_o, outstanding_o
   );

   // Fetch unit / control side
   modport slave (
      output stall_i, jump_flag_i, jump_addr_i, fetch_ack_i,
      input  valid_o, inst_addr_o, kill_o, outstanding_o
   );
endinterface

// File: rtl/pc_gen_way0.sv
// Program-counter generator feeding the way-0 fetch unit.
// Issues sequential fetch addresses, caps in-flight fetches at MAX_OUTSTANDING,
// and on a redirect drains in-flight fetches (kill_o high) before restarting
// at the jump target.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-high reset
//   bus    pc_gen_way0_if.master (stall/jump/ack in; valid/addr/kill/count out)
module pc_gen_way0 #(
   parameter logic [31:0] RESET_PC        = 32'h8000_0000,
   parameter logic [31:0] WAY_OFFSET      = 32'h0,
   parameter logic [31:0] PC_STEP         = 32'h8,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic         clk,
   input  logic         reset,
   pc_gen_way0_if.master bus
);

   localparam int unsigned CW       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [31:0] PC_RESET = RESET_PC | WAY_OFFSET;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          issue_c;
   logic          retire_c;
   logic [31:0]   jump_pc_c;

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= PC_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Issue/retire, counter, pc and next-state logic
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      issue_c   = 1'b0;
      retire_c  = 1'b0;
      // Target is aligned to the 8-byte fetch pair, then offset to this way
      jump_pc_c = (bus.jump_addr_i & ~32'h7) | WAY_OFFSET;

      issue_c  = (state_q == RUN) && (cnt_q < CW'(MAX_OUTSTANDING)) &&
                 !bus.stall_i && !bus.jump_flag_i;
      // Acks with nothing in flight are spurious and dropped
      retire_c = bus.fetch_ack_i && (cnt_q != '0);
      cnt_d    = cnt_q + CW'(issue_c) - CW'(retire_c);

      if (bus.jump_flag_i) begin
         pc_d = jump_pc_c;
      end else if (issue_c) begin
         pc_d = pc_q + PC_STEP;
      end

      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            // A jump with nothing left in flight restarts immediately
            if (bus.jump_flag_i && (cnt_d != '0)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // A repeat jump only reloads pc; leaving depends solely on the count
            if (cnt_d == '0) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   assign bus.valid_o       = issue_c;
   assign bus.inst_addr_o   = pc_q;
   assign bus.kill_o        = (state_q == DRAIN);
   assign bus.outstanding_o = cnt_q;

endmodule
